// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 states, command codes and frame helpers
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, RELEASE, DONE} state_t;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO = 8'hEE;
  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK = 8'hFA;
  localparam int FRAME_BITS = 11;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
  function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] d);
    return {1'b1, odd_parity(d), d, 1'b0};
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: synchronises PS/2 clock/data and flags device clock falls
module ps2_line_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic rst,
  input  logic clk_in,
  input  logic dat_in,
  output logic sync_clk,
  output logic sync_dat,
  output logic fall
);
  logic [STAGES-1:0] clk_sr, dat_sr;
  logic clk_q;
  always_ff @(posedge CLK or negedge rst)
    if (!rst) begin
      clk_sr <= '1;
      dat_sr <= '1;
      clk_q <= 1'b1;
    end else begin
      clk_sr <= STAGES'({clk_sr, clk_in});
      dat_sr <= STAGES'({dat_sr, dat_in});
      clk_q <= sync_clk;
    end
  assign sync_clk = clk_sr[STAGES-1];
  assign sync_dat = dat_sr[STAGES-1];
  assign fall = clk_q && !sync_clk;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: open-drain PS/2 host-to-device command transmitter
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);
  localparam int CW = $clog2((INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] idx, idx_n;
  logic [FRAME_BITS-1:0] frame, frame_n;
  logic nack, nack_n, tmo, tmo_n;
  logic sync_clk, sync_dat, fall, expired;
  ps2_line_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .CLK(CLK),
    .rst(rst),
    .clk_in(ps2_clk_in),
    .dat_in(ps2_dat_in),
    .sync_clk(sync_clk),
    .sync_dat(sync_dat),
    .fall(fall)
  );
  assign expired = cnt == CW'(TIMEOUT_CYCLES - 1) && !fall;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    frame_n = frame;
    nack_n = nack;
    tmo_n = tmo;
    case (state)
      IDLE: if (tx_valid && tx_ready) begin
        state_n = INHIBIT;
        frame_n = ps2_frame(tx_data);
        cnt_n = '0;
        nack_n = 1'b0;
        tmo_n = 1'b0;
      end
      INHIBIT: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
          state_n = REQ;
          cnt_n = '0;
          idx_n = '0;
        end
      end
      REQ: state_n = SEND;
      SEND: if (fall) begin
        idx_n = idx + 1'b1;
        state_n = idx == 4'd9 ? ACK : SEND;
      end
      ACK: if (fall) begin
        nack_n = sync_dat;
        state_n = RELEASE;
      end
      RELEASE: state_n = sync_clk && sync_dat ? DONE : RELEASE;
      default: state_n = IDLE;
    endcase
    // device-clocked phases share one watchdog; a fall on the expiry cycle wins
    if (state inside {REQ, SEND, ACK, RELEASE}) begin
      cnt_n = fall ? '0 : cnt + 1'b1;
      if (expired) begin
        state_n = DONE;
        tmo_n = 1'b1;
      end
    end
  end
  always_ff @(posedge CLK or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      frame <= '0;
      nack <= 1'b0;
      tmo <= 1'b0;
      tx_ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      ack_err <= 1'b0;
      timeout_err <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      frame <= frame_n;
      nack <= nack_n;
      tmo <= tmo_n;
      tx_ready <= state_n == IDLE;
      busy <= state_n != IDLE;
      done <= state_n == DONE;
      ack_err <= state_n == DONE && nack_n && !tmo_n;
      timeout_err <= state_n == DONE && tmo_n;
      ps2_clk_oe <= state_n == INHIBIT;
      ps2_dat_oe <= state_n == REQ || (state_n == SEND && !frame_n[idx_n]);
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: table-driven and random checks of ps2_host_tx against a PS/2 device model
module tb_ps2_host_tx;
  localparam int INH = 60;
  localparam int TMO = 3000;
  localparam int H = 40;
  logic CLK = 1'b0;
  logic rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic tx_ready, ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout_err;
  logic ps2_clk, ps2_dat;
  int checks = 0, errors = 0, dones = 0, viol = 0, accepts = 0;
  bit in_xfer = 0, hold_v = 0, pend = 0;
  bit last_ack, last_to, last_oe, post_rdy, post_busy;
  typedef struct {
    logic [7:0] d;
    bit nack;
    bit hold;
    bit chg;
    bit exp_par;
    bit exp_ack;
  } vec_t;
  vec_t vecs[6];

  assign ps2_clk = ps2_clk_oe ? 1'b0 : dev_clk;
  assign ps2_dat = ps2_dat_oe ? 1'b0 : dev_dat;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .CLK(CLK),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk),
    .ps2_dat_in(ps2_dat),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy(busy),
    .done(done),
    .ack_err(ack_err),
    .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) if (rst && tx_valid && tx_ready) accepts <= accepts + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    if (in_xfer && tx_ready) viol++;
    if (pend) begin
      post_rdy = tx_ready;
      post_busy = busy;
      pend = 0;
    end
    if (done) begin
      dones++;
      pend = 1;
      last_ack = ack_err;
      last_to = timeout_err;
      last_oe = ps2_clk_oe | ps2_dat_oe;
      in_xfer = 0;
      if (hold_v) tx_valid = 1'b0;
    end
  endtask

  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9] = ($countones(d) % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic start_tx(input logic [7:0] d, input bit hold, input bit chg);
    int n;
    step();
    tx_data = d;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 100) begin
      step();
      n++;
    end
    step();
    in_xfer = 1;
    chk("ready_low_after_accept", tx_ready, 0);
    if (!hold) tx_valid = 1'b0;
    if (chg) tx_data = 8'h55;
    n = 0;
    while (ps2_clk_oe && n < INH + 100) begin
      n++;
      step();
    end
    chk("inhibit_cycles", n, INH);
    chk("req_dat_oe", ps2_dat_oe, 1);
    chk("req_clk_released", ps2_clk_oe, 0);
  endtask

  task automatic run(input vec_t v);
    logic [10:0] seen;
    int n, d0, a0, v0;
    d0 = dones;
    a0 = accepts;
    v0 = viol;
    hold_v = v.hold;
    start_tx(v.d, v.hold, v.chg);
    seen[0] = ps2_dat;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) dev_dat = v.nack;
      repeat (H) step();
      dev_clk = 1'b0;
      repeat (H) step();
      if (k <= 10) seen[k] = ps2_dat;
      dev_clk = 1'b1;
    end
    repeat (4) step();
    dev_dat = 1'b1;
    n = 0;
    while (dones == d0 && n < 400) begin
      step();
      n++;
    end
    repeat (3) step();
    hold_v = 0;
    chk("frame", seen, model_frame(v.d));
    chk("parity", seen[9], v.exp_par);
    chk("done_once", dones - d0, 1);
    chk("ack_err", last_ack, v.exp_ack);
    chk("timeout_err_clear", last_to, 0);
    chk("one_accept", accepts - a0, 1);
    chk("ready_low_during_xfer", viol - v0, 0);
    chk("ready_after_done", post_rdy, 1);
    chk("idle_after_done", post_busy, 0);
  endtask

  initial begin
    vec_t rv;
    int n, d0;
    vecs[0] = '{8'hED, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'hED, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    repeat (3) @(negedge CLK);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_outputs", {busy, done, ack_err, timeout_err, ps2_clk_oe, ps2_dat_oe}, 0);
    rst = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 6; i++) run(vecs[i]);
    for (int i = 0; i < 4; i++) begin
      rv.d = 8'($urandom);
      rv.nack = 1'($urandom_range(0, 1));
      rv.hold = 0;
      rv.chg = 0;
      rv.exp_par = ($countones(rv.d) % 2) == 0;
      rv.exp_ack = rv.nack;
      run(rv);
    end
    // device never clocks: watchdog must abort
    d0 = dones;
    start_tx(8'hEE, 0, 0);
    n = 0;
    while (dones == d0 && n < TMO + 100) begin
      step();
      n++;
    end
    step();
    chk("timeout_window", n >= TMO - 3 && n <= TMO + 3, 1);
    chk("timeout_err", last_to, 1);
    chk("timeout_no_ack_err", last_ack, 0);
    chk("timeout_lines_released", last_oe, 0);
    chk("timeout_ready", post_rdy, 1);
    // reset mid-frame after data bit 3 is presented
    start_tx(8'h00, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      repeat (H) step();
      dev_clk = 1'b0;
      if (k < 4) begin
        repeat (H) step();
        dev_clk = 1'b1;
      end
    end
    repeat (H) step();
    chk("pre_reset_dat_oe", ps2_dat_oe, 1);
    #2 rst = 1'b0;
    #1;
    chk("reset_release_clk", ps2_clk_oe, 0);
    chk("reset_release_dat", ps2_dat_oe, 0);
    chk("reset_ready", tx_ready, 1);
    in_xfer = 0;
    dev_clk = 1'b1;
    step();
    rst = 1'b1;
    repeat (5) step();
    run('{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends command bytes to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Sits beside the keyboard receiver on the same PS2_CLK/PS2_DAT pair.
- Lines are open-drain: the block only ever drives a line low or releases it. Top level builds the tri-states (line driven 0 when the *_oe output is 1, otherwise Z).
- Raises busy so the receiver discards line activity during a host transmission.

Parameters:
- INHIBIT_CYCLES, 6000: CLK cycles that PS2_CLK is held low before the request-to-send (120 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000: maximum CLK cycles between device clock falling edges, or waiting for bus idle, before abort (20 ms at 50 MHz).
- SYNC_STAGES, 2: synchroniser depth on ps2_clk_in and ps2_dat_in.

Ports:
- CLK  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- tx_data  input  8  command byte
- tx_valid  input  1  request to send tx_data
- tx_ready  output  1  high only in IDLE; byte accepted when tx_valid && tx_ready
- ps2_clk_in  input  1  sensed PS2_CLK line
- ps2_dat_in  input  1  sensed PS2_DAT line
- ps2_clk_oe  output  1  1 = pull PS2_CLK low
- ps2_dat_oe  output  1  1 = pull PS2_DAT low
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at end of every transfer, success or abort
- ack_err  output  1  one-cycle pulse with done when device ACK bit reads 1
- timeout_err  output  1  one-cycle pulse with done on timeout abort

Behaviour:
- Reset values (async, all outputs registered):
  - tx_ready = 1; busy, done, ack_err, timeout_err, ps2_clk_oe, ps2_dat_oe = 0.
  - State = IDLE; counters = 0.
  - Reset mid-transfer therefore releases both lines immediately.
- Inputs pass through SYNC_STAGES flops. fall = sync_clk was 1 last cycle and is 0 now.
- Frame register holds 11 bits:
  - start 0, data[7:0] LSB first, odd parity (~^tx_data), stop 1.
  - It is latched on the accept cycle, so tx_data may change afterwards.
- IDLE:
  - On accept, go to INHIBIT next cycle.
  - tx_valid while not ready is ignored; no queuing.
- INHIBIT:
  - ps2_clk_oe = 1 for exactly INHIBIT_CYCLES cycles.
  - On the last cycle, go to REQ.
- REQ (start bit):
  - ps2_dat_oe = 1 (start bit 0); ps2_clk_oe = 0 (clock released); bit index = 0; timeout counter cleared.
  - Go to SEND.
- SEND:
  - On each fall, the bit index increments and the next bit is presented: ps2_dat_oe = ~bit.
  - Falls 1–8 present data bits 0–7.
  - Fall 9 presents parity.
  - Fall 10 presents stop: ps2_dat_oe = 0, line released.
  - After fall 10, go to ACK.
- ACK:
  - On fall 11, sample sync_dat: 0 = acknowledged, 1 = ack_err latched.
  - Go to RELEASE.
- RELEASE:
  - Wait until sync_clk = 1 and sync_dat = 1 on the same cycle.
  - Then go to DONE.
- DONE:
  - Single cycle: done = 1, ack_err = latched value.
  - Return to IDLE; tx_ready = 1 on the following cycle.
- Timeout:
  - In REQ/SEND/ACK/RELEASE, the counter increments each cycle and clears on fall.
  - When it reaches TIMEOUT_CYCLES, release both lines and pulse done and timeout_err for one cycle; ack_err = 0. Return to IDLE.
- Line behaviour:
  - ps2_dat_oe changes only on the cycle after a detected fall, i.e. while the device clock is low.
  - The block never drives ps2_clk_oe outside INHIBIT.
- Simultaneous timeout and fall on the same cycle: the fall wins and the counter clears.
- Glitches shorter than the synchroniser depth are not filtered further; the device clock is 10–16.7 kHz, so each fall is seen exactly once.

Decomposition:
- Package ps2_pkg:
  - state enum: IDLE, INHIBIT, REQ, SEND, ACK, RELEASE, DONE
  - constants: PS2_CMD_SET_LEDS = 8'hED, PS2_CMD_ECHO = 8'hEE, PS2_CMD_RESET = 8'hFF, PS2_RSP_ACK = 8'hFA
  - odd-parity function, FRAME_BITS = 11
- Sub-module ps2_line_sync: SYNC_STAGES synchroniser plus falling-edge detect, reusable by the receiver.

Test Plan:
- Send 0xED; bench device model clocks at 12.5 kHz and ACKs with 0.
  - ps2_clk_oe high exactly 6000 cycles.
  - Data bits seen at device rising edges: 0 (start), 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - done pulses once; ack_err = 0.
- Send 0x07:
  - parity bit = 0, stop = 1.
  - Send 0x00: parity = 1.
  - tx_ready low from the accept cycle until the cycle after done.
- Device model ACKs with 1 on clock 11 → done and ack_err pulse together; timeout_err = 0.
- Device model never clocks after REQ → after 1000000 cycles: timeout_err and done pulse, both oe = 0, state IDLE.
- Assert rst low during SEND after bit 3 → same cycle: ps2_clk_oe = ps2_dat_oe = 0, tx_ready = 1. A new 0xFF after release transfers correctly.
- tx_data changed to 0x55 during INHIBIT → transmitted frame still carries 0xED.
- tx_valid held high through busy → exactly one transfer per accept.
